load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage downstream of the instruction decoder.
- Consumes the decoder's store-enable, load-enable and 3-bit databus size code, plus the ALU-computed address and the rs2 store data.
- Runs a request/grant/response transaction on a word-addressed data RAM port.
- For stores: generates byte enables and lane-shifted write data. For loads: lane-extracts and sign/zero-extends the returned word for register writeback. Stalls the core while the access is in flight.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT, 16, maximum cycles in WAIT_R before the access is aborted with an error; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core presents a memory op.
- req_ready  out  1  LSU can accept; high only in IDLE.
- ram_w_enable  in  1  op is a store (from decoder).
- load_en  in  1  op is a load; if both load_en and ram_w_enable are high, the store wins.
- databus  in  3  size code: 000 word, 001 half signed, 010 byte signed, 011 half unsigned, 100 byte unsigned; 101-111 treated as word.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-aligned.
- mem_req  out  1  RAM request.
- mem_we  out  1  RAM write.
- mem_addr  out  ADDR_W  word-aligned address, addr with [1:0] forced to 00.
- mem_be  out  4  byte lane enables.
- mem_wdata  out  32  lane-shifted store data.
- mem_gnt  in  1  RAM accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.
- rdata  out  32  formatted load result; held until the next load completes.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: timeout or misaligned abort.
- busy  out  1  stall to core; high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready=1; mem_req, mem_we, mem_be, done, err, busy=0; rdata, mem_addr, mem_wdata=0; timeout counter=0.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE:
  - req_valid & (load_en | ram_w_enable) → latch op, size, addr and wdata; go to REQ.
  - req_valid with neither enable set → ignored; stay in IDLE; no done pulse.
- REQ: mem_req=1, with mem_we, mem_addr, mem_be and mem_wdata held stable until mem_gnt.
  - gnt on a store → RESP.
  - gnt on a load → WAIT_R; clear the timeout counter.
  - No timeout in REQ; the LSU waits for grant indefinitely.
- WAIT_R: mem_req=0.
  - mem_rvalid → capture the formatted result into rdata; go to RESP.
  - Otherwise increment the counter; when counter reaches TIMEOUT-1 without rvalid → RESP with err=1 and rdata unchanged.
  - mem_rvalid is ignored in every state except WAIT_R.
- RESP: done=1 for exactly one cycle (err as determined); next state IDLE.
- Minimum latency:
  - Store: accept→done = 2 cycles (gnt in first REQ cycle).
  - Load: 3 cycles (rvalid the cycle after gnt).
- Byte enables:
  - word → 1111.
  - half → 0011 << {addr[1],0}.
  - byte → 0001 << addr[1:0].
- Write data:
  - word → wdata.
  - half → {2{wdata[15:0]}}.
  - byte → {4{wdata[7:0]}}.
- Load format:
  - Select the byte or half at the lane given by addr[1:0] (half uses addr[1]).
  - Sign-extend for codes 001/010; zero-extend for 011/100.
- Reset mid-transaction: immediate return to IDLE, all outputs at reset values; a late rvalid after reset is ignored.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠00, is detected at acceptance.
  - The FSM goes IDLE→RESP directly; no mem_req is issued; done=1 and err=1.
- Not defined: addr low bits are silently ignored.
  - Word access uses the aligned word.
  - Half access uses the lane given by addr[1].
  - err is asserted only on timeout.

Test Plan:
- sw addr=0x104 wdata=0xDEADBEEF, gnt in the first REQ cycle → mem_addr=0x104, be=1111, mem_wdata=0xDEADBEEF, mem_we=1; done 2 cycles after accept; err=0.
- sb addr=0x203 wdata=0x000000A5 → be=1000, mem_wdata=0xA5A5A5A5; mem_gnt held low 3 cycles → mem_req stays 1 and outputs stay stable, busy=1 throughout.
- lb addr=0x301, mem_rdata=0x1234F0AA → rdata=0xFFFFFFF0; lbu same stimulus → rdata=0x000000F0; lhu addr=0x302 → rdata=0x00001234.
- Load with rvalid never asserted, TIMEOUT=16 → done & err exactly 16 cycles after entering WAIT_R; rdata keeps its previous value.
- lw addr=0x102 → with MISALIGN_TRAP_EN: done & err 1 cycle after accept, mem_req never 1; without it: mem_addr=0x100, err=0.
- rst_n pulsed low while in WAIT_R, then rvalid arrives → all outputs return to reset values asynchronously, no done pulse, req_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-access stage: request/grant/response RAM transaction with lane steering and load extension.
// Optional build macro MISALIGN_TRAP_EN turns misaligned half/word accesses into an immediate error response.
module load_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              ram_w_enable,
    input  logic              load_en,
    input  logic [2:0]        databus,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

    state_t              state_q, state_d;
    logic                store_q, store_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          off_q, off_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    function automatic logic is_half(input logic [2:0] code);
        return (code == 3'b001) || (code == 3'b011);
    endfunction

    function automatic logic is_byte(input logic [2:0] code);
        return (code == 3'b010) || (code == 3'b100);
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] code, input logic [1:0] off);
        if (is_half(code)) return 4'b0011 << {off[1], 1'b0};
        if (is_byte(code)) return 4'b0001 << off;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] code, input logic [31:0] d);
        if (is_half(code)) return {2{d[15:0]}};
        if (is_byte(code)) return {4{d[7:0]}};
        return d;
    endfunction

    // Pick the addressed lane and extend; codes 001/010 are the signed variants.
    function automatic logic [31:0] load_fmt(input logic [2:0] code, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        logic        sgn;
        byte_sh = word >> {off, 3'b000};
        half_sh = word >> {off[1], 4'b0000};
        sgn     = (code == 3'b001) || (code == 3'b010);
        if (is_half(code)) return {{16{sgn & half_sh[15]}}, half_sh[15:0]};
        if (is_byte(code)) return {{24{sgn & byte_sh[7]}}, byte_sh[7:0]};
        return word;
    endfunction

    function automatic logic misaligned(input logic [2:0] code, input logic [1:0] off);
        if (is_half(code)) return off[0];
        if (is_byte(code)) return 1'b0;
        return off != 2'b00;
    endfunction

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        size_d  = size_q;
        off_d   = off_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid && (load_en || ram_w_enable)) begin
                    store_d = ram_w_enable;
                    size_d  = databus;
                    off_d   = addr[1:0];
                    addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    wdata_d = lane_wdata(databus, wdata);
                    be_d    = lane_be(databus, addr[1:0]);
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = REQ;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned(databus, addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
`endif
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = store_q ? RESP : WAIT_R;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    rdata_d = load_fmt(size_q, off_q, mem_rdata);
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            size_q  <= 3'b000;
            off_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            size_q  <= size_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request-phase signals are only asserted while the request is outstanding.
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_req   = (state_q == REQ);
    assign mem_we    = (state_q == REQ) && store_q;
    assign mem_be    = (state_q == REQ) ? be_q : 4'b0000;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign done      = (state_q == RESP);
    assign err       = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single accesses plus grant-stall, timeout,
// ignored-request, misalignment and mid-transaction reset sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, ram_w_enable, load_en;
    logic [2:0]  databus;
    logic [31:0] addr, wdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, rdata;
    logic [3:0]  mem_be;
    logic        done, err, busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_rd = 32'h0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .ram_w_enable(ram_w_enable), .load_en(load_en), .databus(databus),
        .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rdata(rdata), .done(done), .err(err), .busy(busy)
    );

    typedef struct {
        logic        st;
        logic        ld;
        logic [2:0]  db;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd_in;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] maddr;
        logic [31:0] exp_rd;
        logic        trap;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v, input int i);
        chk($sformatf("v%0d_ready", i), {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; ram_w_enable = v.st; load_en = v.ld;
        databus = v.db; addr = v.a; wdata = v.wd;
        step();
        req_valid = 1'b0; ram_w_enable = 1'b0; load_en = 1'b0;
        if (v.trap) begin
            chk($sformatf("v%0d_trap_done", i), {31'b0, done}, 32'd1);
            chk($sformatf("v%0d_trap_err", i), {31'b0, err}, 32'd1);
            chk($sformatf("v%0d_trap_req", i), {31'b0, mem_req}, 32'd0);
        end else begin
            chk($sformatf("v%0d_req", i), {31'b0, mem_req}, 32'd1);
            chk($sformatf("v%0d_we", i), {31'b0, mem_we}, {31'b0, v.st});
            chk($sformatf("v%0d_addr", i), mem_addr, v.maddr);
            chk($sformatf("v%0d_be", i), {28'b0, mem_be}, {28'b0, v.be});
            if (v.st) chk($sformatf("v%0d_wdata", i), mem_wdata, v.mwd);
            mem_gnt = 1'b1;
            step();
            mem_gnt = 1'b0;
            if (!v.st) begin
                chk($sformatf("v%0d_wait_req", i), {31'b0, mem_req}, 32'd0);
                chk($sformatf("v%0d_wait_done", i), {31'b0, done}, 32'd0);
                mem_rvalid = 1'b1; mem_rdata = v.rd_in;
                step();
                mem_rvalid = 1'b0;
                chk($sformatf("v%0d_rdata", i), rdata, v.exp_rd);
                last_rd = v.exp_rd;
            end
            chk($sformatf("v%0d_done", i), {31'b0, done}, 32'd1);
            chk($sformatf("v%0d_err", i), {31'b0, err}, 32'd0);
        end
        step();
        chk($sformatf("v%0d_done_clr", i), {31'b0, done}, 32'd0);
        chk($sformatf("v%0d_idle", i), {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int cyc;
        logic trap_lw;
`ifdef MISALIGN_TRAP_EN
        trap_lw = 1'b1;
`else
        trap_lw = 1'b0;
`endif
        //        st    ld    db      addr          wdata         mem_rdata     be       mem_wdata     mem_addr      rdata         trap
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        4'b1111, 32'hDEAD_BEEF, 32'h0000_0104, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0203, 32'h0000_00A5, 32'h0,        4'b1000, 32'hA5A5_A5A5, 32'h0000_0200, 32'h0,        1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0206, 32'h0000_BEEF, 32'h0,        4'b1100, 32'hBEEF_BEEF, 32'h0000_0204, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0301, 32'h0,         32'h1234_F0AA, 4'b0010, 32'h0,        32'h0000_0300, 32'hFFFF_FFF0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'b100, 32'h0000_0301, 32'h0,         32'h1234_F0AA, 4'b0010, 32'h0,        32'h0000_0300, 32'h0000_00F0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'b011, 32'h0000_0302, 32'h0,         32'h1234_F0AA, 4'b1100, 32'h0,        32'h0000_0300, 32'h0000_1234, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0300, 32'h0,         32'h0000_8001, 4'b0011, 32'h0,        32'h0000_0300, 32'hFFFF_8001, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0108, 32'h0,         32'hCAFE_F00D, 4'b1111, 32'h0,        32'h0000_0108, 32'hCAFE_F00D, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0303, 32'h0,         32'h8000_0000, 4'b1000, 32'h0,        32'h0000_0300, 32'hFFFF_FF80, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'b111, 32'h0000_010C, 32'h0,         32'h7654_3210, 4'b1111, 32'h0,        32'h0000_010C, 32'h7654_3210, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 3'b000, 32'h0000_0102, 32'h0,         32'h1122_3344, 4'b1111, 32'h0,        32'h0000_0100, 32'h1122_3344, trap_lw};

        rst_n = 1'b0; req_valid = 1'b0; ram_w_enable = 1'b0; load_en = 1'b0;
        databus = 3'b000; addr = 32'h0; wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #12;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) run_op(vecs[i], i);

        // Request with no enable is dropped.
        req_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("ign_busy%0d", k), {31'b0, busy}, 32'd0);
            chk($sformatf("ign_done%0d", k), {31'b0, done}, 32'd0);
        end
        req_valid = 1'b0;

        // Store with grant withheld for three cycles.
        req_valid = 1'b1; ram_w_enable = 1'b1; databus = 3'b010;
        addr = 32'h0000_0203; wdata = 32'h0000_00A5;
        step();
        req_valid = 1'b0; ram_w_enable = 1'b0; wdata = 32'h0; addr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall_req%0d", k), {31'b0, mem_req}, 32'd1);
            chk($sformatf("stall_be%0d", k), {28'b0, mem_be}, 32'h8);
            chk($sformatf("stall_wd%0d", k), mem_wdata, 32'hA5A5_A5A5);
            chk($sformatf("stall_busy%0d", k), {31'b0, busy}, 32'd1);
            step();
        end
        chk("stall_req_last", {31'b0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("stall_done", {31'b0, done}, 32'd1);
        step();

        // Load timeout: rvalid never arrives.
        req_valid = 1'b1; load_en = 1'b1; databus = 3'b000; addr = 32'h0000_0400;
        step();
        req_valid = 1'b0; load_en = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            step();
            cyc++;
        end
        chk("to_cycles", cyc, 32'd16);
        chk("to_err", {31'b0, err}, 32'd1);
        chk("to_rdata", rdata, last_rd);
        step();
        chk("to_idle", {31'b0, req_ready}, 32'd1);

        // Reset while waiting for read data, then a stale rvalid.
        req_valid = 1'b1; load_en = 1'b1; databus = 3'b000; addr = 32'h0000_0500;
        step();
        req_valid = 1'b0; load_en = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("mr_busy_pre", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #2;
        chk("mr_busy", {31'b0, busy}, 32'd0);
        chk("mr_ready", {31'b0, req_ready}, 32'd1);
        chk("mr_addr", mem_addr, 32'h0);
        chk("mr_wdata", mem_wdata, 32'h0);
        chk("mr_rdata", rdata, 32'h0);
        chk("mr_be", {28'b0, mem_be}, 32'h0);
        chk("mr_err", {31'b0, err}, 32'd0);
        step();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_rvalid = 1'b0;
        chk("mr_post_ready", {31'b0, req_ready}, 32'd1);
        chk("mr_post_done", {31'b0, done}, 32'd0);
        chk("mr_post_rdata", rdata, 32'h0);
        step();
        chk("mr_post_done2", {31'b0, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
